// File: rtl/fifo_rd_stream.sv
// Read-side consumer of the async FIFO: turns the pop interface (rempty/rinc/rdata)
// into a valid/ready stream through a 2-entry buffer, counting delivered words.
module fifo_rd_stream #(
    parameter int dw = 8,
    parameter int cw = 16
) (
    input  logic          rclk,
    input  logic          rrst,
    input  logic          rempty,
    input  logic [dw-1:0] rdata,
    output logic          rinc,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [dw-1:0] m_data,
    output logic [cw-1:0] beat_cnt
);

    logic [dw-1:0] mem [2];
    logic          head;
    logic [1:0]    occ;
    logic          inflight;

    logic          pop;
    logic [1:0]    level;
    logic          tail;

    assign m_valid = (occ != 2'd0);
    assign m_data  = mem[head];
    assign pop     = m_valid & m_ready;

    // Occupancy after this edge; occ+inflight never exceeds 2, so 2 bits suffice.
    assign level = occ + {1'b0, inflight} - {1'b0, pop};
    assign rinc  = ~rrst & ~rempty & (level < 2'd2);

    // head+occ mod 2: the captured word always lands behind the current contents.
    assign tail = head ^ occ[0];

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            occ      <= 2'd0;
            inflight <= 1'b0;
            head     <= 1'b0;
            beat_cnt <= '0;
            mem[0]   <= '0;
            mem[1]   <= '0;
        end else begin
            inflight <= rinc;
            occ      <= level;
            if (pop) begin
                head     <= ~head;
                beat_cnt <= beat_cnt + cw'(1);
            end
            if (inflight) begin
                mem[tail] <= rdata;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural FIFO model (registered read).
module tb_fifo_rd_stream;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rrst;
    logic       rempty;
    logic [7:0] rdata;
    logic       rinc, rinc_b;
    logic       m_valid, m_valid_b;
    logic       m_ready;
    logic [7:0] m_data, m_data_b;
    logic [15:0] beat_cnt;
    logic [3:0]  beat_cnt_b;

    logic [7:0] fmem [256];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;

    int compared   = 0;
    int mismatched = 0;
    int rinc_cnt   = 0;
    logic [7:0] got [$];

    assign rempty = (wr_ptr == rd_ptr);

    fifo_rd_stream #(.dw(8), .cw(16)) dut_a (
        .rclk(clk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .beat_cnt(beat_cnt)
    );

    // Narrow-counter instance sees identical inputs; only dut_a pops the FIFO model.
    fifo_rd_stream #(.dw(8), .cw(4)) dut_b (
        .rclk(clk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc_b),
        .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b), .beat_cnt(beat_cnt_b)
    );

    always @(posedge clk) begin
        if (rinc) begin
            rdata  <= fmem[rd_ptr];
            rd_ptr <= rd_ptr + 8'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!rrst) begin
            if (m_valid && m_ready) got.push_back(m_data);
            if (rinc) rinc_cnt++;
            chk("occ_inflight_le2", 32'((32'(dut_a.occ) + 32'(dut_a.inflight)) <= 2), 32'd1);
            chk("rinc_while_empty", 32'(rinc & rempty), 32'd0);
            chk("dut_b_tracks", {rinc_b, m_valid_b, m_data_b}, {rinc, m_valid, m_data});
        end
    end

    task automatic push(input logic [7:0] v);
        fmem[wr_ptr] = v;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rrst    = 1'b1;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        wr_ptr   = rd_ptr;
        got.delete();
        rinc_cnt = 0;
        rrst     = 1'b0;
        #1;
    endtask

    task automatic chk_order(input string tag, input logic [7:0] first, input int n);
        chk({tag, "_count"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < got.size() && i < n; i++)
            chk({tag, "_word"}, 32'(got[i]), 32'(first + 8'(i)));
    endtask

    initial begin
        rrst    = 1'b1;
        m_ready = 1'b0;
        push(8'hEE);
        cyc(1);
        chk("reset_m_valid", 32'(m_valid), 32'd0);
        chk("reset_m_data", 32'(m_data), 32'd0);
        chk("reset_beat_cnt", 32'(beat_cnt), 32'd0);
        chk("reset_rinc", 32'(rinc), 32'd0);

        // Single word
        do_reset();
        m_ready = 1'b1;
        push(8'hA5);
        #1;
        chk("single_rinc_c0", 32'(rinc), 32'd1);
        cyc(1);
        chk("single_rinc_c1", 32'(rinc), 32'd0);
        chk("single_valid_c1", 32'(m_valid), 32'd0);
        cyc(1);
        chk("single_valid_c2", 32'(m_valid), 32'd1);
        chk("single_data_c2", 32'(m_data), 32'hA5);
        chk("single_beat_c2", 32'(beat_cnt), 32'd0);
        cyc(1);
        chk("single_valid_c3", 32'(m_valid), 32'd0);
        chk("single_beat_c3", 32'(beat_cnt), 32'd1);
        chk("single_rinc_cnt", 32'(rinc_cnt), 32'd1);

        // Streaming
        do_reset();
        m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) push(8'(i));
        cyc(2);
        for (int c = 2; c <= 17; c++) begin
            chk("stream_valid", 32'(m_valid), 32'd1);
            chk("stream_data", 32'(m_data), 32'(c - 1));
            cyc(1);
        end
        chk("stream_valid_end", 32'(m_valid), 32'd0);
        chk("stream_beat", 32'(beat_cnt), 32'd16);
        chk("stream_rinc_cnt", 32'(rinc_cnt), 32'd16);

        // Backpressure
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
        cyc(2);
        for (int c = 2; c <= 9; c++) begin
            chk("bp_valid_held", 32'(m_valid), 32'd1);
            chk("bp_data_held", 32'(m_data), 32'h20);
            cyc(1);
        end
        chk("bp_rinc_before_c10", 32'(rinc_cnt), 32'd2);
        m_ready = 1'b1;
        for (int k = 0; k < 40 && got.size() < 8; k++) cyc(1);
        chk_order("bp", 8'h20, 8);

        // Toggle ready
        do_reset();
        for (int i = 0; i < 12; i++) push(8'h50 + 8'(i));
        for (int k = 0; k < 80 && got.size() < 12; k++) begin
            m_ready = (k % 2 == 0);
            cyc(1);
        end
        m_ready = 1'b0;
        chk_order("toggle", 8'h50, 12);
        chk("toggle_rinc_cnt", 32'(rinc_cnt), 32'd12);

        // Empty boundary
        do_reset();
        m_ready = 1'b1;
        push(8'h30); push(8'h31); push(8'h32);
        cyc(2);
        for (int c = 2; c <= 4; c++) begin
            chk("empty_valid", 32'(m_valid), 32'd1);
            chk("empty_data", 32'(m_data), 32'(8'h30 + 8'(c - 2)));
            cyc(1);
        end
        for (int c = 5; c <= 7; c++) begin
            chk("empty_gap_valid", 32'(m_valid), 32'd0);
            cyc(1);
        end
        push(8'h33);
        #1;
        chk("refill_rinc", 32'(rinc), 32'd1);
        cyc(1);
        chk("refill_valid_c1", 32'(m_valid), 32'd0);
        cyc(1);
        chk("refill_valid_c2", 32'(m_valid), 32'd1);
        chk("refill_data_c2", 32'(m_data), 32'h33);
        cyc(1);
        chk("refill_beat", 32'(beat_cnt), 32'd4);
        chk("refill_valid_end", 32'(m_valid), 32'd0);

        // Reset mid-stream with occ=2, inflight=0 and the FIFO still holding words
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'h40 + 8'(i));
        cyc(3);
        chk("mid_pre_occ", 32'(dut_a.occ), 32'd2);
        chk("mid_pre_inflight", 32'(dut_a.inflight), 32'd0);
        chk("mid_pre_data", 32'(m_data), 32'h40);
        #2;
        rrst = 1'b1;
        #1;
        chk("mid_async_valid", 32'(m_valid), 32'd0);
        chk("mid_async_rinc", 32'(rinc), 32'd0);
        chk("mid_async_beat", 32'(beat_cnt), 32'd0);
        chk("mid_async_data", 32'(m_data), 32'd0);
        cyc(1);
        chk("mid_held_rinc", 32'(rinc), 32'd0);
        chk("mid_held_valid", 32'(m_valid), 32'd0);
        wr_ptr   = rd_ptr;
        got.delete();
        rinc_cnt = 0;
        rrst     = 1'b0;
        m_ready  = 1'b1;
        push(8'h44);
        #1;
        chk("mid_rearm_rinc", 32'(rinc), 32'd1);
        cyc(2);
        chk("mid_rearm_valid", 32'(m_valid), 32'd1);
        chk("mid_rearm_data", 32'(m_data), 32'h44);
        cyc(1);
        chk("mid_rearm_beat", 32'(beat_cnt), 32'd1);

        // Counter wrap on the 4-bit instance
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 17; i++) push(8'h60 + 8'(i));
        cyc(18);
        chk("wrap_beat16_narrow", 32'(beat_cnt_b), 32'd0);
        chk("wrap_beat16_wide", 32'(beat_cnt), 32'd16);
        cyc(1);
        chk("wrap_beat17_narrow", 32'(beat_cnt_b), 32'd1);
        chk("wrap_beat17_wide", 32'(beat_cnt), 32'd17);
        chk_order("wrap", 8'h60, 17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
